alu32_seq_ctrl: RTL and testbench
=================================

// Module: alu32_seq_ctrl
// PURPOSE
//  Multi-cycle command sequencer that drives the 32-bit ALU (initiator side of its a/b/op/result interface).
//  Owns an 8x32 register file, accepts register-addressed commands over a valid/ready handshake,
//  issues operands and op to the ALU, then writes the result back. Sits between host/test logic and alu32.
// PARAMETERS
//  NREG   8   register-file depth (power of 2); address width AW = log2(NREG)
//  DW     32  datapath width; must match ALU width
// PORTS
//  clk         in   1   single clock, rising edge
//  reset_n     in   1   asynchronous active-low reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   sequencer can accept a command
//  cmd_op      in   4   ALU op code: 0 ~a,1 ~b,2 and,3 or,4 xor,5 xnor,6 a<b,7 a>b,8 LSL b,9 LSR b,10 ASR b,11 add,12 sub
//  cmd_ra      in   AW  source register A
//  cmd_rb      in   AW  source register B
//  cmd_rd      in   AW  destination register
//  wr_en       in   1   host direct register write
//  wr_addr     in   AW  host write address
//  wr_data     in   DW  host write data
//  rd_addr     in   AW  host read address
//  rd_data     out  DW  combinational register read
//  alu_a       out  DW  registered ALU operand A
//  alu_b       out  DW  registered ALU operand B
//  alu_op      out  4   registered ALU op
//  alu_result  in   DW  combinational ALU result
//  done        out  1   one-cycle pulse on write-back
//  zero        out  1   result==0 of last completed command
//  err         out  1   sticky illegal-op flag (ALU_ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all registers 0, alu_a/alu_b 0, alu_op 0, done 0, zero 0, err 0, state IDLE; mid-command reset aborts, no write-back.
//  FSM IDLE->READ->EXEC->WB->IDLE, one cycle each; no back-pressure from ALU.
//  cmd_ready = (state==IDLE) & ~wr_en; transfer when cmd_valid & cmd_ready (cycle 0); ra/rb/rd/op latched.
//  READ (cycle 1): alu_a<=R[ra], alu_b<=R[rb], alu_op<=op.  EXEC (cycle 2): res<=alu_result.
//  WB (cycle 3): R[rd]<=res, done=1, zero<=(res==0). cmd_ready high again in cycle 4; throughput 1 cmd / 4 cycles.
//  Host write: honoured only in IDLE; in other states wr_en ignored. wr_en in IDLE blocks command acceptance that cycle.
//  rd_data = R[rd_addr] combinational; read of rd during WB cycle returns old value, new value from next cycle.
//  ra==rb==rd legal: operands sampled in READ, so result uses pre-command values.
//  Shifts are by 1 on operand B only; a ignored for ops 1,8,9,10. Compare ops yield ALU output as-is.
//  Add/sub wrap modulo 2^DW; no carry/overflow output.
// CONFIGURATION
//  ALU_ILLEGAL_TRAP_EN defined: ops 13-15 still run the FSM but WB skips the register write, done pulses,
//   zero unchanged, err set to 1 and held until reset.
//  Not defined: ops 13-15 processed as any op (ALU output written to R[rd], X in sim); err tied 0.
// TESTING
//  1) Reset: assert reset_n=0 mid-EXEC -> all outputs 0, R[rd] unchanged, cmd_ready=1 after release.
//  2) wr R1=0x0000_0005, R2=0x0000_0003; cmd op=11 ra=1 rb=2 rd=3 -> done in cycle 3, R3=0x0000_0008, zero=0.
//  3) cmd op=12 ra=1 rb=1 rd=4 -> R4=0x0000_0000, zero=1; op=12 ra=2 rb=1 rd=5 -> R5=0xFFFF_FFFE.
//  4) R6=0x8000_0001; op=10 rb=6 rd=7 -> R7=0xC000_0000; op=8 rb=6 rd=7 -> R7=0x0000_0002.
//  5) Back-to-back cmd_valid held high -> accepts every 4th cycle; wr_en=1 in IDLE -> cmd_ready=0 that cycle.
//  6) ALU_ILLEGAL_TRAP_EN: op=14 rd=3 -> R3 unchanged, done=1, err=1 sticky; without macro err stays 0.

Source files
------------

// File: rtl/alu32_seq_ctrl.sv
// alu32_seq_ctrl: 4-cycle register-file command sequencer driving an external 32-bit ALU.
// Optional ALU_ILLEGAL_TRAP_EN: ops 13-15 skip write-back and set a sticky err flag.
module alu32_seq_ctrl #(
  parameter int NREG = 8,
  parameter int DW = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  output logic          done,
  output logic          zero,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] res;
  logic [3:0] op_q;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic fire, wb_wr;
  always_comb begin
    cmd_ready = (state == IDLE) & ~wr_en;
    fire = cmd_valid & cmd_ready;
    done = state == WB;
    state_nx = state == IDLE ? (fire ? READ : IDLE) :
               state == READ ? EXEC :
               state == EXEC ? WB : IDLE;
  end
  assign rd_data = regs[rd_addr];
`ifdef ALU_ILLEGAL_TRAP_EN
  assign wb_wr = done & (op_q <= 4'd12);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err <= 1'b0;
    else if (done & ~wb_wr) err <= 1'b1;
`else
  assign wb_wr = done;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      res <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rd_q <= '0;
      zero <= 1'b0;
    end else begin
      if (fire) begin
        op_q <= cmd_op;
        ra_q <= cmd_ra;
        rb_q <= cmd_rb;
        rd_q <= cmd_rd;
      end
      if (state == IDLE && wr_en) regs[wr_addr] <= wr_data;
      if (state == READ) begin
        alu_a <= regs[ra_q];
        alu_b <= regs[rb_q];
        alu_op <= op_q;
      end
      if (state == EXEC) res <= alu_result;
      if (wb_wr) begin
        regs[rd_q] <= res;
        zero <= res == '0;
      end
    end
endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// tb_alu32_seq_ctrl: acts as the ALU, tracks the register file at transaction level and checks every cycle.
module tb_alu32_seq_ctrl;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, wr_en = 1'b0, done, zero, err;
  logic [3:0] cmd_op = '0, alu_op;
  logic [2:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0, wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0, rd_data, alu_a, alu_b, alu_result;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;

  alu32_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .zero(zero), .err(err)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: alu_f = ~a;
      4'd1: alu_f = ~b;
      4'd2: alu_f = a & b;
      4'd3: alu_f = a | b;
      4'd4: alu_f = a ^ b;
      4'd5: alu_f = ~(a ^ b);
      4'd6: alu_f = {31'd0, a < b};
      4'd7: alu_f = {31'd0, a > b};
      4'd8: alu_f = b << 1;
      4'd9: alu_f = b >> 1;
      4'd10: alu_f = $signed(b) >>> 1;
      4'd11: alu_f = a + b;
      4'd12: alu_f = a - b;
      default: alu_f = '0;
    endcase
  endfunction
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: commands complete 3 cycles after acceptance; phase counts cycles since acceptance.
  logic [31:0] m_regs [8];
  int phase = 0;
  logic [3:0] p_op = '0, e_op = '0;
  logic [2:0] p_ra = '0, p_rb = '0, p_rd = '0;
  logic [31:0] p_res = '0, e_a = '0, e_b = '0;
  logic e_zero = 1'b0, e_err = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      phase = 0; e_a = '0; e_b = '0; e_op = '0; e_zero = 1'b0; e_err = 1'b0;
    end else if (phase == 0) begin
      if (wr_en) m_regs[wr_addr] = wr_data;
      else if (cmd_valid) begin
        p_op = cmd_op; p_ra = cmd_ra; p_rb = cmd_rb; p_rd = cmd_rd;
        p_res = alu_f(cmd_op, m_regs[cmd_ra], m_regs[cmd_rb]);
        phase = 1;
      end
    end else if (phase == 1) begin
      e_a = m_regs[p_ra]; e_b = m_regs[p_rb]; e_op = p_op;
      phase = 2;
    end else if (phase == 2) phase = 3;
    else begin
      phase = 0;
      if (TRAP && p_op > 4'd12) e_err = 1'b1;
      else begin
        m_regs[p_rd] = p_res;
        e_zero = p_res == 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, phase == 0 && !wr_en);
    chk("done", done, phase == 3);
    chk("zero", zero, e_zero);
    chk("err", err, e_err);
    chk("rd_data", rd_data, m_regs[rd_addr]);
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("alu_op", alu_op, e_op);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd);
    int t = 0;
    logic acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    while (!acc && t < 8) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
      t++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", acc, 1);
    tick();
    tick();
    @(negedge clk);
    chk("done_cycle3", done, 1);
    tick();
  endtask

  task automatic peek(input string nm, input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(nm, rd_data, exp);
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_err", err, 0);
    host_wr(3'd1, 32'h0000_0005);
    host_wr(3'd2, 32'h0000_0003);
    cmd(4'd11, 3'd1, 3'd2, 3'd3);
    peek("add_r3", 3'd3, 32'h0000_0008);
    chk("add_zero", zero, 0);
    cmd(4'd12, 3'd1, 3'd1, 3'd4);
    peek("sub_r4", 3'd4, 32'h0000_0000);
    chk("sub_zero", zero, 1);
    cmd(4'd12, 3'd2, 3'd1, 3'd5);
    peek("sub_r5", 3'd5, 32'hFFFF_FFFE);
    host_wr(3'd6, 32'h8000_0001);
    cmd(4'd10, 3'd0, 3'd6, 3'd7);
    peek("asr_r7", 3'd7, 32'hC000_0000);
    cmd(4'd8, 3'd0, 3'd6, 3'd7);
    peek("lsl_r7", 3'd7, 32'h0000_0002);
    // Abort during EXEC: no write-back may land in R0 after reset.
    cmd_valid = 1'b1; cmd_op = 4'd11; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    tick();
    tick();
    reset_n = 1'b1;
    peek("abort_r0", 3'd0, 32'h0);
    peek("abort_r1", 3'd1, 32'h0);
    chk("abort_ready_after", cmd_ready, 1);
    host_wr(3'd1, 32'h0000_0010);
    cnt = 0;
    cmd_valid = 1'b1; cmd_op = 4'd11; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cnt += int'(cmd_ready);
      tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", cnt, 4);
    peek("b2b_r2", 3'd2, 32'h0000_0020);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hA5A5_0000; cmd_valid = 1'b1;
    @(negedge clk);
    chk("wr_blocks_ready", cmd_ready, 0);
    tick();
    wr_en = 1'b0; cmd_valid = 1'b0;
    peek("wr_r4", 3'd4, 32'hA5A5_0000);
    host_wr(3'd3, 32'h0000_1234);
    cmd(4'd14, 3'd1, 3'd2, 3'd3);
`ifdef ALU_ILLEGAL_TRAP_EN
    peek("trap_r3", 3'd3, 32'h0000_1234);
    chk("trap_err", err, 1);
    cmd(4'd11, 3'd1, 3'd1, 3'd5);
    chk("trap_err_sticky", err, 1);
`else
    chk("notrap_err", err, 0);
`endif
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 4'($urandom_range(0, 15));
      cmd_ra = 3'($urandom_range(0, 7));
      cmd_rb = 3'($urandom_range(0, 7));
      cmd_rd = 3'($urandom_range(0, 7));
      wr_en = $urandom_range(0, 3) == 0;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      rd_addr = 3'($urandom_range(0, 7));
      tick();
    end
    cmd_valid = 1'b0; wr_en = 1'b0;
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
